audio_pwm_dac: RTL
==================

// Module: audio_pwm_dac
// PURPOSE
//  Audio output stage between the CPU's memory-mapped audio register and the board's aud_pwm/aud_sd pins.
//  Buffers unsigned PCM samples in a small FIFO. Plays out one sample per PWM period as a duty cycle.
//  Drives the amplifier enable.
//  Upstream: CPU MMIO write path (valid/ready). Downstream: z1top pins aud_pwm, aud_sd.
// PARAMETERS
//  SAMPLE_WIDTH  10  sample/duty width W; PWM period = 2^W clk cycles
//  FIFO_DEPTH    8   sample FIFO entries (power of 2, >=2)
// PORTS
//  clk              in   1                    system clock (125 MHz)
//  rst              in   1                    asynchronous, active-high reset
//  sample_in        in   W                    unsigned PCM sample = duty (high cycles per period)
//  sample_in_valid  in   1                    producer has a sample
//  sample_in_ready  out  1                    FIFO can accept (count < FIFO_DEPTH)
//  enable           in   1                    playback enable (CPU control bit)
//  fifo_count       out  clog2(DEPTH)+1       current FIFO occupancy
//  underflow        out  1                    sticky: a period ended with the FIFO empty
//  underflow_clear  in   1                    one-cycle pulse, clears underflow
//  aud_pwm          out  1                    PWM output, registered
//  aud_sd           out  1                    amplifier enable, 1 = on, registered
// BEHAVIOUR
//  Reset (async, rst=1):
//   - FIFO empty, fifo_count=0, state IDLE, cnt=0, duty=0
//   - aud_pwm=0, aud_sd=0, underflow=0
//   - sample_in_ready=1 immediately after reset is released
//  FIFO:
//   - push when sample_in_valid && sample_in_ready
//   - sample_in_ready decodes the registered count, so a push is refused while full even if a pop occurs that cycle
//   - push+pop in the same cycle: count unchanged, data order preserved
//   - read/write pointers wrap modulo FIFO_DEPTH
//   - pushes are accepted in every state, including IDLE
//  FSM:
//   - IDLE: cnt held at 0, aud_pwm=0, aud_sd=0
//     - enable=1 -> PRIME
//   - PRIME: aud_sd=1, aud_pwm=0
//     - wait for fifo_count>0, then pop into duty, cnt<=0 -> RUN
//     - enable=0 -> IDLE
//   - RUN: aud_sd=1, cnt increments every cycle and wraps 2^W-1 -> 0
//     - aud_pwm <= (cnt < duty), registered, one cycle behind cnt
//     - at cnt==2^W-1, FIFO non-empty: pop and load duty; new duty takes effect at cnt=0
//     - at cnt==2^W-1, FIFO empty: underflow<=1, duty handling per CONFIGURATION, stay RUN
//     - enable=0 at any cycle -> IDLE next cycle: aud_pwm=0 and aud_sd=0 the cycle after; FIFO contents kept, no pop
//  Duty bounds: duty=0 -> aud_pwm never high; duty=2^W-1 -> high 2^W-1 of 2^W cycles; exact count, no off-by-one.
//  Underflow set and underflow_clear in the same cycle: set wins.
//  Latency: sample pushed into an empty FIFO during RUN -> drives aud_pwm from the next period start (cnt=0)
//   plus 1 cycle of output register.
//  Reset mid-period: all outputs low immediately (async); no partial period resumes.
// CONFIGURATION
//  AUD_UNDERFLOW_MIDSCALE_EN defined: on underflow duty <= 2^(W-1) (midscale, silence for AC-coupled output).
//  Not defined (default): on underflow duty holds the last sample.
//  underflow flag behaves identically in both builds.
// TESTING
//  1 Reset: rst pulse mid-run -> aud_pwm=0, aud_sd=0, fifo_count=0, sample_in_ready=1 within the rst assertion.
//  2 Push 256 with enable=1, W=10 -> RUN; each 1024-cycle period shows exactly 256 aud_pwm-high cycles;
//    underflow=1 after the first period ends with the FIFO empty.
//  3 Push 0,1023,512 back-to-back, enable=1 -> periods show 0, 1023, 512 high cycles in order;
//    fourth period per config: 512 held (default) or 512 midscale (EN).
//  4 Fill 8 with enable=0 -> fifo_count=8, ready=0, a 9th push is not taken;
//    enable=1 -> ready=1 after the first pop; first period duty = first pushed value.
//  5 Full FIFO with valid held high at a period boundary (pop) -> no push that cycle, push next cycle,
//    fifo_count returns to 8.
//  6 Underflow with underflow_clear pulsed on the same cycle -> underflow stays 1;
//    clear on a later cycle -> underflow=0.
//    Build with AUD_UNDERFLOW_MIDSCALE_EN after last sample 100 -> next period 512 high cycles.

Source files
------------

// File: rtl/audio_pwm_dac.sv
// audio_pwm_dac: PCM sample FIFO feeding a PWM DAC for the board audio pins.
// Each sample sets the number of high cycles in one 2^SAMPLE_WIDTH-cycle PWM period.
// aud_sd enables the external amplifier whenever playback is enabled.
// Optional build macro AUD_UNDERFLOW_MIDSCALE_EN: on underflow the duty falls back to
// midscale (2^(W-1)) instead of repeating the last sample.
module audio_pwm_dac #(
    parameter int SAMPLE_WIDTH = 10,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SAMPLE_WIDTH-1:0]         sample_in,
    input  logic                            sample_in_valid,
    output logic                            sample_in_ready,
    input  logic                            enable,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            underflow,
    input  logic                            underflow_clear,
    output logic                            aud_pwm,
    output logic                            aud_sd
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [SAMPLE_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);
`ifdef AUD_UNDERFLOW_MIDSCALE_EN
    localparam logic [SAMPLE_WIDTH-1:0] MIDSCALE = {1'b1, {(SAMPLE_WIDTH - 1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t                  state;
    logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [SAMPLE_WIDTH-1:0] cnt;
    logic [SAMPLE_WIDTH-1:0] duty;
    logic                    push;
    logic                    pop;
    logic                    fifo_empty;
    logic                    period_end;
    logic                    underflow_set;

    // Ready decodes only the registered count: a full FIFO refuses a push even when a pop
    // happens in the same cycle.
    assign sample_in_ready = (fifo_count < DEPTH_C);
    assign push            = sample_in_valid && sample_in_ready;
    assign fifo_empty      = (fifo_count == '0);
    assign period_end      = (state == RUN) && enable && (cnt == CNT_MAX);
    assign pop             = !fifo_empty && (period_end || ((state == PRIME) && enable));
    assign underflow_set   = period_end && fifo_empty;

    // Sample storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    // FIFO pointers wrap naturally (power-of-two depth); count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Playback FSM with the period counter, duty register and registered pin outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            duty    <= '0;
            aud_pwm <= 1'b0;
            aud_sd  <= 1'b0;
        end else begin
            aud_pwm <= (state == RUN) && (cnt < duty);
            aud_sd  <= (state != IDLE);
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (enable) begin
                        state <= PRIME;
                    end
                end
                PRIME: begin
                    cnt <= '0;
                    if (!enable) begin
                        state <= IDLE;
                    end else if (!fifo_empty) begin
                        duty  <= mem[rd_ptr];
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_MAX) begin
                            if (!fifo_empty) begin
                                duty <= mem[rd_ptr];
                            end else begin
`ifdef AUD_UNDERFLOW_MIDSCALE_EN
                                duty <= MIDSCALE;
`else
                                duty <= duty;
`endif
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Sticky underflow flag; a new underflow beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow <= 1'b0;
        end else if (underflow_set) begin
            underflow <= 1'b1;
        end else if (underflow_clear) begin
            underflow <= 1'b0;
        end
    end

endmodule
